// File: rtl/gamepad_pkg.sv
`default_nettype none
// ============================================================================
// gamepad_pkg : shared types, sizing helpers and SNES bit indices
// Revision    : 1.0
// ============================================================================
package gamepad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int total_bits(input int num_pads, input int bits_per_pad);
    return num_pads * bits_per_pad;
  endfunction

  // Wide enough to hold the value TOTAL itself, not just TOTAL-1.
  function automatic int cnt_width(input int total);
    return $clog2(total + 1);
  endfunction

  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

endpackage
`default_nettype wire

// File: rtl/gamepad_rx_sync_edge.sv
`default_nettype none
// ============================================================================
// sync_edge : multi-flop synchroniser with a one-cycle rising-edge pulse
// Revision  : 1.0
// ============================================================================
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/gamepad_rx.sv
`default_nettype none
// ============================================================================
// gamepad_rx : daisy-chained NES/SNES pad receiver with frame checking
// Revision   : 1.0
// ============================================================================
module gamepad_rx
  import gamepad_pkg::*;
#(
  parameter int NUM_PADS       = 2,
  parameter int BITS_PER_PAD   = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             game_latch,
  input  logic                             game_clk,
  input  logic                             game_data,
  output logic [NUM_PADS*BITS_PER_PAD-1:0] buttons,
  output logic [NUM_PADS-1:0]              pad_present,
  output logic                             frame_valid,
  output logic                             frame_err,
  output logic [CNT_W-1:0]                 frame_count
);

  localparam int TOTAL = total_bits(NUM_PADS, BITS_PER_PAD);
  localparam int CW    = cnt_width(TOTAL);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0]    CNT_FULL = CW'(TOTAL);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic latch_rise, clk_rise, data_s;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (game_latch),
    .rise     (latch_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (game_clk),
    .rise     (clk_rise)
  );

  // Data uses the same depth as game_clk so a sample lines up with its edge.
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], game_data};
  assign data_s      = data_sync_q[SYNC_STAGES-1];

  state_t                   state_q, state_d;
  logic [TOTAL-1:0]         shreg_q, shreg_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     overrun_q, overrun_d;
  logic [TOTAL-1:0]         buttons_q, buttons_d;
  logic [NUM_PADS-1:0]      present_q, present_d;
  logic                     fvalid_q, fvalid_d;
  logic                     ferr_q, ferr_d;
  logic [CNT_W-1:0]         fcount_q, fcount_d;
  logic [NUM_PADS-1:0]      pad_absent;

  // A pulled-down data line reads as all-ones after inversion.
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    assign pad_absent[p] = &shreg_q[p*BITS_PER_PAD +: BITS_PER_PAD];
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    overrun_d = overrun_q;
    buttons_d = buttons_q;
    present_d = present_q;
    fvalid_d  = 1'b0;
    ferr_d    = 1'b0;
    fcount_d  = fcount_q;

    case (state_q)
      IDLE: begin
        if (latch_rise) begin
          state_d = SHIFT;
          shreg_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end

      SHIFT: begin
        if (latch_rise) begin
          if (cnt_q != '0) ferr_d = 1'b1;
          shreg_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (clk_rise) begin
          shreg_d = {~data_s, shreg_q[TOTAL-1:1]};
          cnt_d   = cnt_q + 1'b1;
          tmo_d   = '0;
          if (cnt_q == CNT_FULL - 1'b1) state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      DONE: begin
        // cnt_q still holds TOTAL only on the entry cycle.
        if (cnt_q == CNT_FULL) begin
          for (int p = 0; p < NUM_PADS; p++) begin
            if (pad_absent[p]) begin
              buttons_d[p*BITS_PER_PAD +: BITS_PER_PAD] = '0;
              present_d[p] = 1'b0;
            end else begin
              buttons_d[p*BITS_PER_PAD +: BITS_PER_PAD] =
                shreg_q[p*BITS_PER_PAD +: BITS_PER_PAD];
              present_d[p] = 1'b1;
            end
          end
          fvalid_d = 1'b1;
          fcount_d = fcount_q + 1'b1;
          cnt_d    = '0;
        end
        if (latch_rise) begin
          if (overrun_q) ferr_d = 1'b1;
          state_d   = SHIFT;
          shreg_d   = '0;
          cnt_d     = '0;
          tmo_d     = '0;
          overrun_d = 1'b0;
        end else if (clk_rise) begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sync_q <= '0;
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      overrun_q   <= 1'b0;
      buttons_q   <= '0;
      present_q   <= '0;
      fvalid_q    <= 1'b0;
      ferr_q      <= 1'b0;
      fcount_q    <= '0;
    end else begin
      data_sync_q <= data_sync_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      overrun_q   <= overrun_d;
      buttons_q   <= buttons_d;
      present_q   <= present_d;
      fvalid_q    <= fvalid_d;
      ferr_q      <= ferr_d;
      fcount_q    <= fcount_d;
    end
  end

  assign buttons     = buttons_q;
  assign pad_present = present_q;
  assign frame_valid = fvalid_q;
  assign frame_err   = ferr_q;
  assign frame_count = fcount_q;

endmodule
`default_nettype wire

// File: tb/tb_gamepad_rx.sv
`default_nettype none
// ============================================================================
// tb_gamepad_rx : randomized self-checking bench with a frame-level model
// Revision      : 1.0
// ============================================================================
module tb_gamepad_rx;

  localparam int NP  = 2;
  localparam int BP  = 12;
  localparam int TOT = NP * BP;
  localparam int SS  = 2;
  localparam int TMO = 4096;

  logic clk = 1'b0, rst = 1'b1;
  logic game_latch = 1'b0, game_clk = 1'b0, game_data = 1'b0;

  logic [TOT-1:0] buttons, buttons_w;
  logic [NP-1:0]  pad_present, pad_present_w;
  logic           fv, fe, fv_w, fe_w;
  logic [7:0]     frame_count;
  logic [1:0]     frame_count_w;

  gamepad_rx #(.NUM_PADS(NP), .BITS_PER_PAD(BP), .SYNC_STAGES(SS),
               .TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .game_latch(game_latch), .game_clk(game_clk),
    .game_data(game_data), .buttons(buttons), .pad_present(pad_present),
    .frame_valid(fv), .frame_err(fe), .frame_count(frame_count)
  );

  gamepad_rx #(.NUM_PADS(NP), .BITS_PER_PAD(BP), .SYNC_STAGES(SS),
               .TIMEOUT_CYCLES(TMO), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .game_latch(game_latch), .game_clk(game_clk),
    .game_data(game_data), .buttons(buttons_w), .pad_present(pad_present_w),
    .frame_valid(fv_w), .frame_err(fe_w), .frame_count(frame_count_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int pcyc = 0, last_rise = 0, err_cyc = 0;
  int nv = 0, ne = 0, nvw = 0, new_e = 0, viol = 0;

  logic [TOT-1:0] exp_buttons = '0;
  logic [NP-1:0]  exp_present = '0;
  int exp_count = 0, exp_nv = 0, exp_ne = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  always @(negedge clk) begin
    if (fv) nv++;
    if (fe) begin ne++; err_cyc = pcyc; end
    if (fv_w) nvw++;
    if (fe_w) new_e++;
    if ((fv && fe) || (fv_w && fe_w)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_latch();
    game_latch = 1'b1; cyc(4);
    game_latch = 1'b0; cyc(4);
  endtask

  task automatic send_bit(input logic b);
    game_data = b; cyc(2);
    game_clk  = 1'b1; last_rise = pcyc; cyc(4);
    game_clk  = 1'b0; cyc(2);
  endtask

  task automatic send_frame(input logic [TOT-1:0] w, input int nclk);
    pulse_latch();
    for (int i = 0; i < nclk; i++)
      send_bit(i < TOT ? w[i] : 1'($urandom_range(0, 1)));
    cyc(10);
  endtask

  // Wire bits are active-low; a pad whose bits are all 0 is unplugged.
  task automatic model_good(input logic [TOT-1:0] w);
    logic [BP-1:0] s;
    for (int p = 0; p < NP; p++) begin
      s = w[p*BP +: BP];
      exp_present[p] = (s != '0);
      exp_buttons[p*BP +: BP] = (s != '0) ? ~s : '0;
    end
    exp_count++;
    exp_nv++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_buttons"}, 32'(buttons), 32'(exp_buttons));
    chk({tag, "_present"}, 32'(pad_present), 32'(exp_present));
    chk({tag, "_count"}, 32'(frame_count), 32'(exp_count % 256));
    chk({tag, "_count_w"}, 32'(frame_count_w), 32'(exp_count % 4));
    chk({tag, "_nvalid"}, 32'(nv), 32'(exp_nv));
    chk({tag, "_nerr"}, 32'(ne), 32'(exp_ne));
  endtask

  task automatic short_frame(input int k);
    pulse_latch();
    for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)));
    pulse_latch();
    cyc(10);
    exp_ne++;
  endtask

  task automatic overrun_frame(input logic [TOT-1:0] w, input int extra);
    send_frame(w, TOT + extra);
    model_good(w);
    check_all("overrun_pub");
    pulse_latch();
    cyc(10);
    exp_ne++;
    check_all("overrun_err");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [TOT-1:0] w;
    int kind;

    cyc(5);
    chk("rst_buttons", 32'(buttons), 32'h0);
    chk("rst_count", 32'(frame_count), 32'h0);
    rst = 1'b0;
    cyc(5);
    check_all("reset");

    w = {12'hFFF, 12'hFFE};
    send_frame(w, TOT);
    model_good(w);
    chk("tp1_buttons", 32'(buttons), 32'h000001);
    chk("tp1_present", 32'(pad_present), 32'h3);
    check_all("tp1");

    w = {12'h000, 12'h7FF};
    send_frame(w, TOT);
    model_good(w);
    chk("tp2_buttons", 32'(buttons), 32'h000800);
    chk("tp2_present", 32'(pad_present), 32'h1);
    check_all("tp2");

    short_frame(10);
    check_all("short");
    w = {12'hF0F, 12'h5A5};
    send_frame(w, TOT);
    model_good(w);
    check_all("after_short");

    pulse_latch();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    cyc(TMO + 20);
    exp_ne++;
    check_all("timeout");
    chk("timeout_latency", 32'(err_cyc - last_rise), 32'(TMO + SS + 1));
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    cyc(10);
    check_all("idle_ignores_clk");
    w = {12'h123, 12'hABC};
    send_frame(w, TOT);
    model_good(w);
    check_all("after_timeout");

    overrun_frame({12'hEEE, 12'h0F0}, 2);

    for (int r = 0; r < 20; r++) begin
      w = TOT'($urandom);
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 3) == 0) w[p*BP +: BP] = '0;
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        short_frame($urandom_range(1, TOT - 1));
        check_all("rnd_short");
      end else if (kind == 1) begin
        overrun_frame(w, $urandom_range(1, 3));
      end else begin
        send_frame(w, TOT);
        model_good(w);
        check_all("rnd_good");
      end
    end

    chk("w_nvalid", 32'(nvw), 32'(exp_nv));
    chk("w_nerr", 32'(new_e), 32'(exp_ne));
    chk("w_buttons", 32'(buttons_w), 32'(exp_buttons));
    chk("valid_err_exclusive", 32'(viol), 32'h0);

    pulse_latch();
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
    rst = 1'b1;
    #1;
    chk("midrst_buttons", 32'(buttons), 32'h0);
    chk("midrst_present", 32'(pad_present), 32'h0);
    chk("midrst_count", 32'(frame_count), 32'h0);
    chk("midrst_count_w", 32'(frame_count_w), 32'h0);
    chk("midrst_pulses", 32'({fv, fe, fv_w, fe_w}), 32'h0);
    chk("midrst_buttons_w", 32'({buttons_w, pad_present_w}), 32'h0);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
